// File: rtl/mixcolumn_iter.sv
// mixcolumn_iter: sequential AES MixColumns stage.
//
// Accepts a 128-bit AES state on a valid/ready handshake and transforms it
// COLS_PER_CYCLE columns per cycle over NUM_STEPS = 4/COLS_PER_CYCLE BUSY
// cycles. It then presents the result on a valid/ready output handshake.
// Column c sits at bits [127-32c -: 32], and row 0 is the MSB byte.
//
// Optional feature macro: MIXCOL_INV_EN
//   defined   - the inverse datapath is built, and in_inv picks the transform per block.
//   undefined - only the forward transform exists, and in_inv is ignored.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   input block valid
//   in_ready   high only in IDLE
//   in_data    128-bit input state
//   in_inv     1 = inverse MixColumns (sampled with in_data)
//   out_valid  result valid (DONE)
//   out_ready  downstream accepts the result
//   out_data   transformed state
//   busy       high in BUSY or DONE
module mixcolumn_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int NUM_STEPS = 4 / COLS_PER_CYCLE;
    localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [STEP_W-1:0] STEP_ZERO = STEP_W'(0);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mixcolumn_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Multiply by 2 in GF(2^8), reduced by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward column transform: b_r = 2a_r ^ 3a_(r+1) ^ a_(r+2) ^ a_(r+3).
    function automatic logic [31:0] mix_fwd(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] b [4];
        for (int r = 0; r < 4; r++) begin
            a[r] = col[31-8*r -: 8];
        end
        for (int r = 0; r < 4; r++) begin
            b[r] = xtime(a[r]) ^ xtime(a[(r+1)%4]) ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
        return {b[0], b[1], b[2], b[3]};
    endfunction

`ifdef MIXCOL_INV_EN
    // Inverse column transform: b_r = 0E a_r ^ 0B a_(r+1) ^ 0D a_(r+2) ^ 09 a_(r+3).
    // The 9/B/D/E products are built from the x2/x4/x8 terms of chained xtime.
    function automatic logic [31:0] mix_inv(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] b  [4];
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
        end
        for (int r = 0; r < 4; r++) begin
            b[r] = (x8[r] ^ x4[r] ^ x2[r])
                 ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                 ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                 ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
        end
        return {b[0], b[1], b[2], b[3]};
    endfunction
`endif

    state_e              state_q;
    logic [STEP_W-1:0]   step_q;
    logic [127:0]        data_q;
    logic [127:0]        res_q;
    logic [127:0]        res_d;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;
    logic [1:0]          col_idx_s [COLS_PER_CYCLE];
    logic [31:0]         col_in_s  [COLS_PER_CYCLE];
    logic [31:0]         col_out_s [COLS_PER_CYCLE];

`ifdef MIXCOL_INV_EN
    logic                inv_q;
`else
    logic                unused_inv_s;
    assign unused_inv_s = in_inv;
`endif

    // Column datapath: C copies, each picks column step*C+k from the latched state.
    always_comb begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            col_idx_s[k] = 2'(int'(step_q) * COLS_PER_CYCLE + k);
            case (col_idx_s[k])
                2'd0:    col_in_s[k] = data_q[127:96];
                2'd1:    col_in_s[k] = data_q[95:64];
                2'd2:    col_in_s[k] = data_q[63:32];
                2'd3:    col_in_s[k] = data_q[31:0];
                default: col_in_s[k] = 32'h0000_0000;
            endcase
`ifdef MIXCOL_INV_EN
            col_out_s[k] = inv_q ? mix_inv(col_in_s[k]) : mix_fwd(col_in_s[k]);
`else
            col_out_s[k] = mix_fwd(col_in_s[k]);
`endif
        end
    end

    // Result merge: overwrite only the columns handled this step.
    always_comb begin
        logic [31:0] col_v;
        res_d = res_q;
        for (int c = 0; c < 4; c++) begin
            col_v = res_q[127-32*c -: 32];
            for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                col_v = (col_idx_s[k] == 2'(c)) ? col_out_s[k] : col_v;
            end
            res_d[127-32*c -: 32] = col_v;
        end
    end

    // Control FSM with registered handshake/status outputs and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_q      <= STEP_ZERO;
            data_q      <= 128'h0;
            res_q       <= 128'h0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MIXCOL_INV_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        data_q     <= in_data;
`ifdef MIXCOL_INV_EN
                        inv_q      <= in_inv;
`endif
                        step_q     <= STEP_ZERO;
                        state_q    <= ST_BUSY;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    res_q <= res_d;
                    if (step_q == STEP_LAST) begin
                        step_q      <= STEP_ZERO;
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        step_q <= step_q + STEP_ONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    step_q      <= STEP_ZERO;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = res_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mixcolumn_iter.sv
// Testbench for mixcolumn_iter.
// It drives three instances: COLS_PER_CYCLE = 1, 2 and 4.
// Expected results are pushed into a scoreboard when a block is accepted.
// A negedge monitor pops each expected result and compares it on every
// output handshake.
module tb_mixcolumn_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [2:0]          in_valid_v;
    logic [2:0]          in_inv_v;
    logic [2:0]          out_ready_v;
    logic [2:0]          in_ready_v;
    logic [2:0]          out_valid_v;
    logic [2:0]          busy_v;
    logic [2:0][127:0]   in_data_v;
    logic [2:0][127:0]   out_data_v;

    mixcolumn_iter #(.COLS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_data(in_data_v[0]), .in_inv(in_inv_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .out_data(out_data_v[0]), .busy(busy_v[0])
    );

    mixcolumn_iter #(.COLS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_data(in_data_v[1]), .in_inv(in_inv_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .out_data(out_data_v[1]), .busy(busy_v[1])
    );

    mixcolumn_iter #(.COLS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in_data(in_data_v[2]), .in_inv(in_inv_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .out_data(out_data_v[2]), .busy(busy_v[2])
    );

    // Hand-computed vectors; the outputs are FIPS-197 column results, rearranged.
    localparam logic [127:0] VEC_A   = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] VEC_A_F = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] VEC_B   = 128'hf20a225c_db135345_2d26314c_c6c6c6c6;
    localparam logic [127:0] VEC_B_F = 128'h9fdc589d_8e4da1bc_4d7ebdf8_c6c6c6c6;
    localparam logic [127:0] VEC_C   = 128'hc6c6c6c6_d4d4d4d5_00000000_ffffffff;
    localparam logic [127:0] VEC_C_F = 128'hc6c6c6c6_d5d5d7d6_00000000_ffffffff;
    localparam logic [127:0] VEC_D   = 128'hd4d4d4d5_ffffffff_db135345_00000000;
    localparam logic [127:0] VEC_D_F = 128'hd5d5d7d6_ffffffff_8e4da1bc_00000000;

    int           n_vec = 0;
    int           n_bad = 0;
    logic [127:0] exp_data_q [$];
    int           exp_id_q   [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst && out_valid_v[i] && out_ready_v[i]) begin
                if (exp_data_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_output inst %0d: got %h expected none", i, out_data_v[i]);
                end else begin
                    check("out_inst", 128'(i), 128'(exp_id_q.pop_front()));
                    check("out_data", out_data_v[i], exp_data_q.pop_front());
                end
            end
        end
    end

    // Offers one block, keeps junk on the inputs while the block is in flight,
    // and checks the accept-to-out_valid latency.
    task automatic send(input int id, input logic [127:0] d, input logic inv,
                        input logic [127:0] e, input int lat);
        int cyc;
        @(negedge clk);
        check("in_ready_idle", 128'(in_ready_v[id]), 128'(1));
        in_valid_v[id] = 1'b1;
        in_data_v[id]  = d;
        in_inv_v[id]   = inv;
        @(posedge clk);
        exp_data_q.push_back(e);
        exp_id_q.push_back(id);
        #1;
        in_data_v[id] = ~d;
        in_inv_v[id]  = ~inv;
        cyc = 0;
        while (!out_valid_v[id] && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid_v[id] = 1'b0;
        check("latency", 128'(cyc), 128'(lat));
    endtask

    // Completes a handshake with out_ready held high and checks the return to IDLE.
    task automatic finish_block(input int id);
        @(posedge clk);
        #1;
        check("in_ready_after", 128'(in_ready_v[id]), 128'(1));
        check("out_valid_after", 128'(out_valid_v[id]), 128'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        in_valid_v  = 3'b000;
        in_inv_v    = 3'b000;
        out_ready_v = 3'b111;
        in_data_v   = '0;
        #2;
        for (int i = 0; i < 3; i += 2) begin
            check("rst_in_ready", 128'(in_ready_v[i]), 128'(1));
            check("rst_out_valid", 128'(out_valid_v[i]), 128'(0));
            check("rst_busy", 128'(busy_v[i]), 128'(0));
            check("rst_out_data", out_data_v[i], 128'h0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // C=1 forward, including a column-permuted vector
        send(0, VEC_A, 1'b0, VEC_A_F, 4); finish_block(0);
        send(0, VEC_B, 1'b0, VEC_B_F, 4); finish_block(0);
`ifdef MIXCOL_INV_EN
        send(0, VEC_A_F, 1'b1, VEC_A, 4); finish_block(0);
        send(1, VEC_A_F, 1'b1, VEC_A, 2); finish_block(1);
        send(1, VEC_B_F, 1'b1, VEC_B, 2); finish_block(1);
`else
        send(0, VEC_A, 1'b1, VEC_A_F, 4); finish_block(0);
        send(1, VEC_A, 1'b0, VEC_A_F, 2); finish_block(1);
        send(1, VEC_B, 1'b1, VEC_B_F, 2); finish_block(1);
`endif
        send(1, VEC_D, 1'b0, VEC_D_F, 2); finish_block(1);
        send(2, VEC_C, 1'b0, VEC_C_F, 1); finish_block(2);
        send(2, VEC_D, 1'b0, VEC_D_F, 1); finish_block(2);
        send(2, VEC_A, 1'b0, VEC_A_F, 1); finish_block(2);

        // Backpressure: hold DONE for 10 cycles while the inputs toggle.
        out_ready_v[0] = 1'b0;
        send(0, VEC_C, 1'b0, VEC_C_F, 4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_data", out_data_v[0], VEC_C_F);
            check("bp_in_ready", 128'(in_ready_v[0]), 128'(0));
            check("bp_busy", 128'(busy_v[0]), 128'(1));
            check("bp_out_valid", 128'(out_valid_v[0]), 128'(1));
            in_valid_v[0] = i[0];
            in_data_v[0]  = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        @(posedge clk);
        #1;
        in_valid_v[0]  = 1'b0;
        out_ready_v[0] = 1'b1;
        finish_block(0);
        check("bp_busy_idle", 128'(busy_v[0]), 128'(0));

        // Asynchronous reset during BUSY step 1, between clock edges.
        @(negedge clk);
        in_valid_v[0] = 1'b1;
        in_data_v[0]  = VEC_A;
        in_inv_v[0]   = 1'b0;
        @(posedge clk);
        #1;
        in_valid_v[0] = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 128'(in_ready_v[0]), 128'(1));
        check("mid_rst_out_valid", 128'(out_valid_v[0]), 128'(0));
        check("mid_rst_out_data", out_data_v[0], 128'h0);
        check("mid_rst_busy", 128'(busy_v[0]), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        send(0, VEC_D, 1'b0, VEC_D_F, 4); finish_block(0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 128'(exp_data_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
